// File: rtl/alu_exec32.sv
// RV32 execute stage: single-cycle add/sub/logic/compare, bit-serial shifts,
// valid/ready handshakes on both sides and a registered result.
module alu_exec32 #(
   parameter int XLEN     = 32,
   parameter int OP_WIDTH = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OP_WIDTH-1:0] op,
   input  logic [XLEN-1:0]     rs1,
   input  logic [XLEN-1:0]     rs2,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     result,
   output logic                err
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            err_q, err_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [2:0]      shk_q, shk_d;   // one-hot {sra, srl, sll}
   logic [XLEN-1:0] alu_val;
   logic            accept, op_onehot, op_is_shift;

   assign op_onehot   = (op != '0) && ((op & (op - OP_WIDTH'(1))) == '0);
   assign op_is_shift = |op[7:5];
   assign in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept      = in_valid && in_ready;
   assign out_valid   = (state_q == DONE);
   assign result      = result_q;
   assign err         = err_q;

   // Only consulted when op is known to be one-hot.
   always_comb begin
      alu_val = '0;
      case (1'b1)
         op[0]: alu_val = rs1 + rs2;
         op[1]: alu_val = rs1 - rs2;
         op[2]: alu_val = rs1 & rs2;
         op[3]: alu_val = rs1 | rs2;
         op[4]: alu_val = rs1 ^ rs2;
         op[8]: alu_val = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
         op[9]: alu_val = {{(XLEN-1){1'b0}}, rs1 < rs2};
         default: alu_val = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      shk_d    = shk_q;

      case (state_q)
         SHIFT: begin
            cnt_d = cnt_q - 5'd1;
            if (shk_q[0])
               result_d = result_q << 1;
            else if (shk_q[1])
               result_d = result_q >> 1;
            else
               result_d = {result_q[XLEN-1], result_q[XLEN-1:1]};
            if (cnt_q == 5'd1)
               state_d = DONE;
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: ;
      endcase

      // A new accept overrides the DONE->IDLE drain so results stream back-to-back.
      if (accept) begin
         if (!op_onehot) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = DONE;
         end else if (op_is_shift) begin
            result_d = rs1;
            err_d    = 1'b0;
            shk_d    = op[7:5];
            cnt_d    = rs2[4:0];
            state_d  = (rs2[4:0] == 5'd0) ? DONE : SHIFT;
         end else begin
            result_d = alu_val;
            err_d    = 1'b0;
            state_d  = DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         shk_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         shk_q    <= shk_d;
      end
   end

endmodule

// File: tb/tb_alu_exec32.sv
// Bench for alu_exec32: directed corner cases plus randomized ops checked
// against an arithmetic reference model.
module tb_alu_exec32;

   localparam logic [9:0] OP_ADD  = 10'b0000000001;
   localparam logic [9:0] OP_SUB  = 10'b0000000010;
   localparam logic [9:0] OP_AND  = 10'b0000000100;
   localparam logic [9:0] OP_OR   = 10'b0000001000;
   localparam logic [9:0] OP_XOR  = 10'b0000010000;
   localparam logic [9:0] OP_SLL  = 10'b0000100000;
   localparam logic [9:0] OP_SRL  = 10'b0001000000;
   localparam logic [9:0] OP_SRA  = 10'b0010000000;
   localparam logic [9:0] OP_SLT  = 10'b0100000000;
   localparam logic [9:0] OP_SLTU = 10'b1000000000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [9:0]  op = '0;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        err;

   int vectors = 0;
   int miscompares = 0;

   alu_exec32 #(.XLEN(32), .OP_WIDTH(10)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rs1(rs1), .rs2(rs2),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Returns {err, result} straight from the operation definitions.
   function automatic logic [32:0] model(input logic [9:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      sa = a;
      if ($countones(o) != 1) return {1'b1, 32'h0};
      if (o == OP_ADD)  return {1'b0, a + b};
      if (o == OP_SUB)  return {1'b0, a - b};
      if (o == OP_AND)  return {1'b0, a & b};
      if (o == OP_OR)   return {1'b0, a | b};
      if (o == OP_XOR)  return {1'b0, a ^ b};
      if (o == OP_SLL)  return {1'b0, a << b[4:0]};
      if (o == OP_SRL)  return {1'b0, a >> b[4:0]};
      if (o == OP_SRA)  return {1'b0, 32'(sa >>> b[4:0])};
      if (o == OP_SLT)  return {1'b0, (sa < $signed(b)) ? 32'h1 : 32'h0};
      return {1'b0, (a < b) ? 32'h1 : 32'h0};
   endfunction

   // Called just after a negedge with the block idle; returns just after a negedge, idle again.
   task automatic run_op(input string tag, input logic [9:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int stall);
      logic [32:0] m;
      logic [31:0] held;
      int lat, exp_lat;
      m = model(o, a, b);
      exp_lat = ($countones(o) == 1 && (o[7:5] != 3'b0)) ? 1 + int'(b[4:0]) : 1;
      in_valid = 1'b1; op = o; rs1 = a; rs2 = b;
      #1 chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'h1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 64) begin
         chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'h0);
         @(negedge clk);
         lat++;
      end
      chk({tag, ".out_valid"}, 32'(out_valid), 32'h1);
      chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".result"}, result, m[31:0]);
      chk({tag, ".err"}, 32'(err), 32'(m[32]));
      held = result;
      repeat (stall) begin
         @(negedge clk);
         chk({tag, ".stall_result"}, result, held);
         chk({tag, ".stall_in_ready"}, 32'(in_ready), 32'h0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".drained"}, 32'(out_valid), 32'h0);
   endtask

   initial begin
      logic [9:0]  ro;
      logic [31:0] ra, rb;
      int seen;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset.out_valid", 32'(out_valid), 32'h0);
      chk("reset.result", result, 32'h0);
      chk("reset.err", 32'(err), 32'h0);
      chk("reset.in_ready", 32'(in_ready), 32'h1);
      @(negedge clk);

      run_op("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 0);
      run_op("sub_wrap", OP_SUB, 32'h0, 32'h1, 0);
      run_op("slt_neg", OP_SLT, 32'hFFFFFFFF, 32'h1, 0);
      run_op("sltu_big", OP_SLTU, 32'hFFFFFFFF, 32'h1, 0);
      run_op("and", OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
      run_op("or", OP_OR, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
      run_op("xor", OP_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
      run_op("sra31", OP_SRA, 32'h80000000, 32'h0000003F, 0);
      run_op("srl31", OP_SRL, 32'h80000000, 32'h0000003F, 0);
      run_op("sll0", OP_SLL, 32'h1, 32'h0, 0);
      run_op("illegal_zero", 10'b0, 32'h12345678, 32'h9, 0);
      run_op("illegal_two", 10'b0000000011, 32'h12345678, 32'h9, 0);
      run_op("legal_after_err", OP_ADD, 32'h5, 32'h6, 0);

      // Consumer stall, then a back-to-back xor accepted on the draining edge.
      in_valid = 1'b1; op = OP_ADD; rs1 = 32'h100; rs2 = 32'h23;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("stall.add_valid", 32'(out_valid), 32'h1);
      chk("stall.add_result", result, 32'h123);
      repeat (5) begin
         @(negedge clk);
         chk("stall.result_held", result, 32'h123);
         chk("stall.in_ready_low", 32'(in_ready), 32'h0);
         chk("stall.valid_held", 32'(out_valid), 32'h1);
      end
      in_valid = 1'b1; op = OP_XOR; rs1 = 32'hAAAA5555; rs2 = 32'h0F0F0F0F; out_ready = 1'b1;
      #1 chk("b2b.in_ready", 32'(in_ready), 32'h1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b.valid", 32'(out_valid), 32'h1);
      chk("b2b.result", result, 32'hA5A55A5A);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Reset in the middle of a 20-position shift.
      in_valid = 1'b1; op = OP_SLL; rs1 = 32'h1; rs2 = 32'd20;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid.out_valid", 32'(out_valid), 32'h0);
      chk("rst_mid.result", result, 32'h0);
      chk("rst_mid.err", 32'(err), 32'h0);
      rst = 1'b0;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("rst_mid.no_stale", 32'(seen), 32'h0);
      run_op("add_after_rst", OP_ADD, 32'hDEAD0000, 32'h0000BEEF, 0);

      for (int i = 0; i < 40; i++) begin
         int sel;
         sel = int'($urandom_range(0, 11));
         if (sel < 10) ro = 10'(1) << sel;
         else if (sel == 10) ro = 10'b0;
         else ro = 10'($urandom);
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000000F;
         run_op("rand", ro, ra, rb, int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_exec32.md
# alu_exec32

Iterative RV32 integer execute stage that consumes the 10-bit one-hot ALU operation code produced by the ALU decode stage, together with two 32-bit operands. It returns a registered 32-bit result. Add, subtract, logic and compare operations complete in one cycle. Shifts run bit-serially, one position per cycle. Both the input side and the output side use valid/ready handshakes, so the block can sit between decode/operand-fetch and writeback with stalls on either side.

## Interface
Parameters:
- XLEN, 32, operand and result width (only 32 is supported).
- OP_WIDTH, 10, width of the one-hot operation code.

Ports:
- clk  input  1  single clock; every register updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  the operation and operands are valid.
- in_ready  output  1  the block can accept an operation this cycle.
- op  input  OP_WIDTH  one-hot operation select. Bit assignments: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu.
- rs1  input  XLEN  operand A; this is the value that is shifted.
- rs2  input  XLEN  operand B; for shifts only rs2[4:0] is used as the shift amount.
- out_valid  output  1  result and err are valid.
- out_ready  input  1  the consumer takes the result this cycle.
- result  output  XLEN  registered result.
- err  output  1  the accepted op was not exactly one-hot.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready and never depends on in_valid.
- An operation is accepted on any edge where in_valid && in_ready.
- Behaviour on accept:
  - op is exactly one-hot and not a shift: result <= f(rs1, rs2) and err <= 0; go to DONE.
  - op is a shift: result <= rs1; the shift kind is latched; cnt (5 bits) <= rs2[4:0]. Go to DONE if rs2[4:0]==0, otherwise go to SHIFT.
  - op is zero or has more than one bit set: result <= 0, err <= 1; go to DONE.
- Arithmetic rules:
  - add and sub are modulo 2^32; carry and overflow are discarded.
  - slt is a signed compare and sltu an unsigned compare; the result is 32'h1 or 32'h0.
  - and, or and xor are bitwise.
- SHIFT state:
  - Each cycle: sll does result <= result<<1; srl does result <= result>>1 (zero fill); sra does result <= {result[31], result[31:1]}.
  - Each cycle: cnt <= cnt-1. On the edge where cnt==1, go to DONE.
  - No new operation is accepted while in SHIFT.
- DONE state:
  - out_valid = 1.
  - result and err are held stable while out_ready==0.
  - out_ready==1 with no new accept: go to IDLE.
  - out_ready==1 with a new accept on the same edge: the new operation is loaded directly, with the same next-state rules as from IDLE. The back-to-back throughput is one op per cycle for non-shift ops.
- rst asserted in any state, including mid-shift: the next edge forces IDLE, clears result, err and cnt, and abandons the operation in flight. No out_valid pulse is produced for it.

## Timing
- Reset values: out_valid=0, result=0, err=0. in_ready=1 in the first cycle after rst deasserts.
- Latency is counted from the accept edge to the first cycle with out_valid high:
  - non-shift op, shift by 0, or illegal op: 1 cycle.
  - shift by s (1..31): 1+s cycles.
- out_valid is a decoded state (state==DONE). It is a registered output and has no combinational path from any input.
- result and err are registers. They change only on an accept edge or a SHIFT edge, never while out_valid && !out_ready.
- A consumer stall of any length is lossless; in_ready stays low throughout the stall.

## Test plan
- Reset, then add with rs1=32'h7FFFFFFF, rs2=1 → after 1 cycle out_valid=1, result=32'h80000000, err=0. Repeat with sub, rs1=0, rs2=1 → 32'hFFFFFFFF.
- slt/sltu with rs1=32'hFFFFFFFF, rs2=1 → slt gives 1, sltu gives 0. Then and/or/xor with rs1=32'hF0F0F0F0, rs2=32'h0FF00FF0 → 32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00.
- sra with rs1=32'h80000000, rs2=32'h0000003F (shift amount 31) → in_ready low for 31 cycles, result=32'hFFFFFFFF on cycle 32. Also srl with the same operands → 32'h00000001. Also sll with rs1=1, rs2=0 → result 1 after 1 cycle.
- Illegal op values 10'b0 and 10'b0000000011 → result=0, err=1 after 1 cycle. A following legal op clears err.
- Hold out_ready=0 for 5 cycles after an add completes → result stable and in_ready=0 throughout. Then pulse out_ready with in_valid high and xor pending → the xor result appears on the next cycle with no idle gap.
- Assert rst during the 10th cycle of a 20-bit shift → next cycle out_valid=0 and result=0. No stale completion follows; a new add accepted afterwards completes normally.
